piso_arb_ctrl: RTL and testbench

PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_shift_core.sv | 56 +++++
 rtl/piso_arb_ctrl.sv | 145 ++++++++++++++
 tb/tb_piso_arb_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the arbitrated parallel-in/serial-out block.
// Optional feature macro: PISO_ARB_PARITY_EN (adds one even-parity bit per frame).
package piso_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
`ifdef PISO_ARB_PARITY_EN
        ST_PAR   = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/piso_shift_core.sv
// Serializer datapath: parallel load, shift right with zero fill, bit 0 drives
// the serial output, and a bit counter that flags the last data bit.
// Optional feature macro: PISO_ARB_PARITY_EN (parity bit enters bit 0 after the
// last data shift, so the serial output stays a plain flop output).
module piso_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] word,
    output logic             q_bit,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    bitcnt_reg;
`ifdef PISO_ARB_PARITY_EN
    logic             par_reg;
`endif

    assign q_bit = shreg_reg[0];
    assign last  = (bitcnt_reg == CW'(WIDTH - 1));

    // Load a word or shift it out one bit per cycle; the register drains to zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shreg_reg  <= '0;
            bitcnt_reg <= '0;
`ifdef PISO_ARB_PARITY_EN
            par_reg    <= 1'b0;
`endif
        end else if (load) begin
            shreg_reg  <= word;
            bitcnt_reg <= '0;
`ifdef PISO_ARB_PARITY_EN
            par_reg    <= ^word;
`endif
        end else if (shift) begin
            bitcnt_reg <= bitcnt_reg + CW'(1);
`ifdef PISO_ARB_PARITY_EN
            if (last) begin
                shreg_reg <= WIDTH'(par_reg);
            end else begin
                shreg_reg <= {1'b0, shreg_reg[WIDTH-1:1]};
            end
`else
            shreg_reg <= {1'b0, shreg_reg[WIDTH-1:1]};
`endif
        end
    end

endmodule

// File: rtl/piso_arb_ctrl.sv
// Round-robin arbiter in front of a shared serializer. One requester at a time
// gets a registered one-hot grant and its word is shifted out LSB first.
// Optional feature macro: PISO_ARB_PARITY_EN (appends an even-parity bit).
module piso_arb_ctrl
    import piso_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] d,
    output logic [NREQ-1:0]       gnt,
    output logic                  q,
    output logic                  q_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = $clog2(NREQ);

    state_t            state_reg, state_next;
    logic [IW-1:0]     rr_reg, rr_next;
    logic [IW-1:0]     gidx_reg, gidx_next;
    logic [IW-1:0]     pick_idx;
    logic              pick_found;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic              q_valid_reg, q_valid_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              core_load, core_shift, core_last, core_bit;
    logic [WIDTH-1:0]  words [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign words[gi] = d[gi*WIDTH +: WIDTH];
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_reg;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req[(int'(rr_reg) + k) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(rr_reg) + k) % NREQ);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (|req) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if (core_last) begin
`ifdef PISO_ARB_PARITY_EN
                state_next = ST_PAR;
`else
                state_next = ST_DONE;
`endif
            end
`ifdef PISO_ARB_PARITY_EN
            ST_PAR:   state_next = ST_DONE;
`endif
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output and bookkeeping values for the next cycle; outputs are all registered.
    always_comb begin
        gnt_next  = gnt_reg;
        gidx_next = gidx_reg;
        rr_next   = rr_reg;
        case (state_reg)
            ST_IDLE: if (|req) begin
                gnt_next  = NREQ'(1) << pick_idx;
                gidx_next = pick_idx;
            end
            ST_DONE: begin
                gnt_next = '0;
                rr_next  = (gidx_reg == IW'(NREQ - 1)) ? '0 : gidx_reg + IW'(1);
            end
            default: ;
        endcase
        q_valid_next = (state_next == ST_SHIFT);
        core_shift   = (state_reg == ST_SHIFT);
`ifdef PISO_ARB_PARITY_EN
        if (state_next == ST_PAR) q_valid_next = 1'b1;
        if (state_reg == ST_PAR)  core_shift   = 1'b1;
`endif
        done_next = (state_next == ST_DONE);
        busy_next = (state_next != ST_IDLE);
        core_load = (state_reg == ST_LOAD);
    end

    // Registered outputs, grant index and round-robin pointer.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gnt_reg     <= '0;
            gidx_reg    <= '0;
            rr_reg      <= '0;
            q_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            gnt_reg     <= gnt_next;
            gidx_reg    <= gidx_next;
            rr_reg      <= rr_next;
            q_valid_reg <= q_valid_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    piso_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .clr   (clr),
        .load  (core_load),
        .shift (core_shift),
        .word  (words[gidx_reg]),
        .q_bit (core_bit),
        .last  (core_last)
    );

    assign gnt     = gnt_reg;
    assign q       = core_bit;
    assign q_valid = q_valid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Scoreboard bench for piso_arb_ctrl: expected frames are queued as stimulus is
// driven, and a negedge monitor rebuilds each serial frame and compares on done.
module tb_piso_arb_ctrl;

    localparam int N = 4;
    localparam int W = 4;
`ifdef PISO_ARB_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = W + PAR;

    typedef struct {
        int           idx;
        logic [W:0]   bits;
    } exp_t;

    logic           clk = 1'b0;
    logic           clr;
    logic [N-1:0]   req;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt;
    logic           q, q_valid, busy, done;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_count = 0;

    piso_arb_ctrl #(.NREQ(N), .WIDTH(W)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] make_bits(input logic [W-1:0] word);
        logic [W:0] b;
        b = {1'b0, word};
        if (PAR != 0) b[W] = ^word;
        return b;
    endfunction

    task automatic push(input int idx, input logic [W-1:0] word);
        exp_t e;
        e.idx  = idx;
        e.bits = make_bits(word);
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (done_count < target && n < 200) begin
            step();
            n++;
        end
        check("frame_timeout", done_count, target);
    endtask

    // One requester set, grant expected on the very next cycle, then req dropped.
    task automatic single_frame(input logic [N-1:0] mask, input int idx, input logic [W-1:0] word);
        int target;
        wait_idle();
        d[idx*W +: W] = word;
        push(idx, word);
        target = done_count + 1;
        req = mask;
        step();
        check("gnt_latency", gnt, 32'd1 << idx);
        req = '0;
        wait_frames(target);
    endtask

    // Monitor: rebuilds frames, checks latency, grant hold and the idle gap.
    initial begin
        int         cyc;
        int         gnt_cyc;
        int         nbits;
        logic [W:0] fbits;
        logic [N-1:0] prev_gnt;
        logic       prev_done;
        exp_t       e;
        cyc = 0; gnt_cyc = 0; nbits = 0; fbits = '0; prev_gnt = '0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr) begin
                nbits = 0;
                fbits = '0;
            end else begin
                if (gnt != '0 && prev_gnt == '0) gnt_cyc = cyc;
                if (q_valid) begin
                    if (nbits == 0) check("lat_first_bit", cyc - gnt_cyc, 1);
                    if (sb.size() > 0) check("gnt_hold", gnt, 32'd1 << sb[0].idx);
                    if (nbits <= W) fbits[nbits] = q;
                    nbits++;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_gnt", gnt, 32'd1 << e.idx);
                        check("frame_bits", fbits, e.bits);
                        check("frame_len", nbits, FLEN);
                        check("lat_done", cyc - gnt_cyc, FLEN + 1);
                        check("done_qvalid", q_valid, 0);
                        $display("frame %0d: idx=%0d bits=%b", done_count, e.idx, fbits);
                    end
                    done_count++;
                    nbits = 0;
                    fbits = '0;
                end
                if (prev_done) check("post_done_idle", {busy, done, gnt}, 0);
            end
            prev_gnt  = gnt;
            prev_done = done;
        end
    end

    initial begin
        int target;
        int n;
        clr = 1'b1;
        req = '0;
        d   = '0;
        step();
        step();
        check("rst_gnt", gnt, 0);
        check("rst_q", q, 0);
        check("rst_qvalid", q_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        clr = 1'b0;

        // Idle hold: nothing may move without a request.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_hold", {busy, gnt, q_valid, done}, 0);
        end

        // Single request from requester 2.
        single_frame(4'b0100, 2, 4'b1011);

        // All requesting after a reset: rotation 0,1,2,3,0.
        wait_idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        d = {4'b1100, 4'b0011, 4'b1010, 4'b0101};
        push(0, 4'b0101);
        push(1, 4'b1010);
        push(2, 4'b0011);
        push(3, 4'b1100);
        push(0, 4'b0101);
        target = done_count + 5;
        req = 4'b1111;
        wait_frames(target);
        req = '0;

        // Mid-frame change of data and request must not disturb the frame.
        wait_idle();
        d[0 +: W] = 4'b0001;
        push(0, 4'b0001);
        target = done_count + 1;
        req = 4'b0001;
        n = 0;
        while (!q_valid && n < 20) begin
            step();
            n++;
        end
        check("midframe_started", q_valid, 1);
        d[0 +: W] = 4'b1110;
        req = '0;
        wait_frames(target);

        // Reset during the second data bit: outputs drop at once, no done.
        wait_idle();
        d[W +: W] = 4'b0111;
        req = 4'b0010;
        step();
        check("rst_mid_gnt", gnt, 4'b0010);
        req = '0;
        step();
        step();
        check("rst_mid_second_bit", q_valid, 1);
        clr = 1'b1;
        #1;
        check("rst_mid_gnt0", gnt, 0);
        check("rst_mid_q0", q, 0);
        check("rst_mid_qvalid0", q_valid, 0);
        check("rst_mid_busy0", busy, 0);
        check("rst_mid_done0", done, 0);
        step();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) step();
        // Pointer restarts at 0 even though requester 1 also asks.
        single_frame(4'b0011, 0, 4'b1001);

        // Requester 1 with 0111 (parity build appends a 1).
        single_frame(4'b0010, 1, 4'b0111);

        wait_idle();
        check("scoreboard_drained", sb.size(), 0);
        check("frame_total", done_count, 9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
